// File: rtl/scratch_mem_arbiter.sv
// scratch_mem_arbiter: shares one single-port scratch memory between three burst
// requesters (0: filter load, 1: image-slice load, 2: result writeback).
// One owner at a time; sequential burst addresses from the latched base/length.
// Optional macro WB_PRIORITY_EN: writeback (requester 2) wins every IDLE decision,
// requesters 0/1 round-robin between themselves. Undefined: plain 3-way round-robin.
// mem_rdata is sampled at the end of each read beat, so rd_valid/rd_data appear
// exactly one cycle after the beat.
`timescale 1ns/1ps
module scratch_mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          req,
   input  logic [3*ADDR_W-1:0] base_addr,
   input  logic [3*LEN_W-1:0]  burst_len,
   input  logic [DATA_W-1:0]   wr_data,
   output logic [2:0]          gnt,
   output logic [2:0]          beat_ack,
   output logic [2:0]          rd_valid,
   output logic [DATA_W-1:0]   rd_data,
   output logic [2:0]          done,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DRAIN = 2'd2} state_t;

   state_t              state;
   state_t              state_next;
   logic [1:0]          owner;
   logic [1:0]          ptr;
   logic [1:0]          winner;
   logic [2:0]          owner_oh;
   logic [ADDR_W-1:0]   base;
   logic [LEN_W-1:0]    len;
   logic [LEN_W-1:0]    beat;
   logic                last_beat;
   logic                read_beat;
   logic [ADDR_W-1:0]   base_slice [3];
   logic [LEN_W-1:0]    len_slice  [3];

   // Unpack the per-requester base/length fields
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_slice
         assign base_slice[gi] = base_addr[gi*ADDR_W +: ADDR_W];
         assign len_slice[gi]  = burst_len[gi*LEN_W +: LEN_W];
      end
   endgenerate

   assign owner_oh  = 3'b001 << owner;
   // A zero-length burst has no beats at all, so it leaves BURST immediately
   assign last_beat = (len == '0) || (beat == len - LEN_W'(1));
   assign read_beat = (state == BURST) && (len != '0) && (owner != 2'd2);

   // Winner selection for the IDLE decision; search starts after the last winner
   always_comb begin
      winner = 2'd0;
`ifdef WB_PRIORITY_EN
      if (req[2])
         winner = 2'd2;
      else if (ptr == 2'd0)
         winner = req[1] ? 2'd1 : 2'd0;
      else
         winner = req[0] ? 2'd0 : 2'd1;
`else
      case (ptr)
         2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
         default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic: IDLE -> BURST -> DRAIN -> IDLE
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req != 3'b000) state_next = BURST;
         BURST:   if (last_beat)     state_next = DRAIN;
         DRAIN:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from state so an async reset clears them at once
   always_comb begin
      gnt       = 3'b000;
      beat_ack  = 3'b000;
      done      = 3'b000;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         BURST: begin
            gnt = owner_oh;
            if (len != '0) begin
               mem_en   = 1'b1;
               beat_ack = owner_oh;
               mem_addr = base + ADDR_W'(beat);
               if (owner == 2'd2) begin
                  mem_we    = 1'b1;
                  mem_wdata = wr_data;
               end
            end
         end
         DRAIN:   done = owner_oh;
         default: ;
      endcase
   end

   // Latch the winner's burst parameters at grant time and count beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner <= 2'd0;
         ptr   <= 2'd2;
         base  <= '0;
         len   <= '0;
         beat  <= '0;
      end else if (state == IDLE && req != 3'b000) begin
         owner <= winner;
         ptr   <= winner;
         base  <= base_slice[winner];
         len   <= len_slice[winner];
         beat  <= '0;
      end else if (state == BURST) begin
         beat  <= beat + LEN_W'(1);
      end
   end

   // Register read data and its per-requester valid one cycle after the beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 3'b000;
         rd_data  <= '0;
      end else begin
         rd_valid <= read_beat ? owner_oh : 3'b000;
         if (read_beat)
            rd_data <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Testbench for scratch_mem_arbiter: directed scenarios plus randomized bursts,
// checked against a transaction-level model (arbitration order, beat timing,
// address sequence and a reference copy of the scratch memory).
`timescale 1ns/1ps
module tb_scratch_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req = 3'b000;
   logic [23:0] base_addr = '0;
   logic [23:0] burst_len = '0;
   logic [31:0] wr_data = '0;
   logic [2:0]  gnt, beat_ack, rd_valid, done;
   logic [31:0] rd_data, mem_wdata, mem_rdata;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr;
   logic        mem_init = 1'b1;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];
   logic [7:0]  base_a  [3];
   logic [7:0]  len_a   [3];
   int          ref_ptr = 2;
   int          n_checks = 0;
   int          n_err = 0;

   scratch_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .LEN_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .base_addr(base_addr),
      .burst_len(burst_len), .wr_data(wr_data), .gnt(gnt), .beat_ack(beat_ack),
      .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .mem_en(mem_en),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pattern(input int k);
      return (k * 32'h9E37_79B1) ^ 32'hA5A5_0000;
   endfunction

   // Scratch memory fixture: asynchronous read, synchronous write
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 256; k++) mem[k] <= pattern(k);
      end else if (mem_en && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference arbitration: round-robin from pointer+1, writeback first if enabled
   function automatic int pick(input logic [2:0] r);
      logic [2:0] rr;
      rr = r;
`ifdef WB_PRIORITY_EN
      if (r[2]) return 2;
      rr[2] = 1'b0;
`endif
      for (int k = 1; k <= 3; k++)
         if (rr[(ref_ptr + k) % 3]) return (ref_ptr + k) % 3;
      return 0;
   endfunction

   task automatic drive_params();
      base_addr = {base_a[2], base_a[1], base_a[0]};
      burst_len = {len_a[2], len_a[1], len_a[0]};
   endtask

   // One arbitration round. Entered #1 into an IDLE cycle; returns #1 into the next IDLE cycle.
   task automatic round(input logic [2:0] r, input bit drop);
      int w, len_v, nb;
      logic [2:0]  oh;
      logic [7:0]  b, a;
      logic [31:0] wd_base, wd, pend_data;
      bit active, pend_rd;
      drive_params();
      req = r;
      w = pick(r);
      ref_ptr = w;
      oh = 3'(1 << w);
      len_v = int'(len_a[w]);
      b = base_a[w];
      nb = (len_v == 0) ? 1 : len_v;
      wd_base = $urandom;
      pend_rd = 1'b0;
      pend_data = '0;
      for (int i = 0; i <= nb; i++) begin
         @(posedge clk); #1;
         active = (i < len_v);
         wd = wd_base + 32'(i);
         wr_data = (w == 2 && active) ? wd : $urandom;
         if (drop && i == 1) req[w] = 1'b0;
         @(negedge clk);
         check("rd_valid", {29'd0, rd_valid}, pend_rd ? {29'd0, oh} : 32'd0);
         if (pend_rd) check("rd_data", rd_data, pend_data);
         if (i < nb) begin
            a = b + 8'(i);
            check("gnt", {29'd0, gnt}, {29'd0, oh});
            check("done_in_burst", {29'd0, done}, 32'd0);
            check("beat_ack", {29'd0, beat_ack}, active ? {29'd0, oh} : 32'd0);
            check("mem_en_we", {30'd0, mem_en, mem_we}, {30'd0, active, active && w == 2});
            if (active) check("mem_addr", {24'd0, mem_addr}, {24'd0, a});
            check("mem_wdata", mem_wdata, (active && w == 2) ? wd : 32'd0);
            if (active && w == 2) ref_mem[a] = wd;
            pend_rd = active && (w != 2);
            pend_data = ref_mem[a];
         end else begin
            check("done", {29'd0, done}, {29'd0, oh});
            check("gnt_drain", {29'd0, gnt}, 32'd0);
            check("mem_en_drain", {31'd0, mem_en}, 32'd0);
         end
      end
      @(posedge clk); #1;
      check("idle_quiet", {20'd0, gnt, done, rd_valid, beat_ack}, 32'd0);
      check("idle_mem_en", {31'd0, mem_en}, 32'd0);
      $display("round req=%b winner=%0d base=%h len=%0d drop=%0d", r, w, b, len_v, drop);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < 256; k++) ref_mem[k] = pattern(k);
      for (int k = 0; k < 3; k++) begin base_a[k] = '0; len_a[k] = '0; end
      repeat (3) @(negedge clk);
      check("rst_ctrl", {17'd0, gnt, beat_ack, rd_valid, done, mem_en, mem_we}, 32'd0);
      check("rst_addr", {24'd0, mem_addr}, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      mem_init = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single read burst
      base_a[0] = 8'h10; len_a[0] = 8'd4;
      round(3'b001, 1'b0);
      // Write burst wrapping the address space
      base_a[2] = 8'hFE; len_a[2] = 8'd3;
      round(3'b100, 1'b0);
      // Read back the wrapped write region
      base_a[1] = 8'hFE; len_a[1] = 8'd3;
      round(3'b010, 1'b0);
      // Contention, all len 2
      for (int k = 0; k < 3; k++) begin base_a[k] = 8'(8'h40 + 8'(k * 16)); len_a[k] = 8'd2; end
      repeat (4) round(3'b111, 1'b0);
      // Zero-length burst
      len_a[1] = 8'd0;
      round(3'b010, 1'b0);
      // Owner drops req mid-burst
      base_a[0] = 8'h80; len_a[0] = 8'd5;
      round(3'b001, 1'b1);

      // Randomized rounds
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < 3; k++) begin
            base_a[k] = 8'($urandom);
            len_a[k]  = 8'($urandom_range(0, 5));
         end
         round(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
      end

      // Reset during beat 2 of a len-8 read burst
      base_a[0] = 8'h20; len_a[0] = 8'd8;
      drive_params();
      req = 3'b001;
      repeat (3) @(posedge clk);
      #2;
      check("pre_abort_en", {31'd0, mem_en}, 32'd1);
      check("pre_abort_addr", {24'd0, mem_addr}, 32'h22);
      rst_n = 1'b0;
      #1;
      check("abort_ctrl", {17'd0, gnt, beat_ack, rd_valid, done, mem_en, mem_we}, 32'd0);
      check("abort_addr", {24'd0, mem_addr}, 32'd0);
      req = 3'b000;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("abort_no_done", {26'd0, done, gnt}, 32'd0);
      end
      rst_n = 1'b1;
      ref_ptr = 2;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) len_a[k] = 8'd2;
      round(3'b111, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
